mmio_adsr: RTL and testbench

MMIO_ADSR -- requirements
Module: mmio_adsr

---
 rtl/mmio_adsr_if.sv | 11 +
 rtl/mmio_adsr.sv | 88 ++++++++
 tb/tb_mmio_adsr.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/mmio_adsr_if.sv
// mmio_adsr_if: MMIO slot bus between a CPU-side master and the ADSR register block.
interface mmio_adsr_if;
    logic        cs;
    logic        write;
    logic        read;
    logic [4:0]  addr;
    logic [31:0] write_data;
    logic [31:0] read_data;
    modport master (output cs, write, read, addr, write_data, input read_data);
    modport slave  (input cs, write, read, addr, write_data, output read_data);
endinterface

// File: rtl/mmio_adsr.sv
// mmio_adsr: MMIO-programmed ADSR envelope generator producing a Q2.14 gain for a DDFS.
module mmio_adsr #(
    parameter logic [31:0] MAX_AMP = 32'h4000_0000
) (
    input  logic             clk,
    input  logic             reset_n,
    mmio_adsr_if.slave       bus,
    output logic [15:0]      env_out
);
    typedef enum logic [2:0] {IDLE, LAUNCH, ATTACK, DECAY, SUSTAIN, RELEASE} state_t;
    state_t state, state_nxt;
    logic [31:0] amp, amp_nxt, timer, timer_nxt;
    logic [31:0] attack_step, decay_step, sustain_level, sustain_time, release_step;
    logic bypass, bypass_nxt, wr, start;
    logic [32:0] sum, tnext;
    logic signed [32:0] diff;
    logic unused_bits;
    assign unused_bits = ^{bus.read, bus.addr[4:3]};
    assign wr = bus.cs & bus.write;
    assign start = wr && bus.addr[2:0] == 3'd0;
    assign bypass_nxt = (wr && bus.addr[2:0] == 3'd6) ? bus.write_data[0] : bypass;
    assign sum = {1'b0, amp} + {1'b0, attack_step};
    assign diff = $signed({1'b0, amp}) - $signed({1'b0, decay_step});
    assign tnext = {1'b0, timer} + 33'd1;
    assign bus.read_data = {15'b0, state == IDLE, env_out};
    always_comb begin
        state_nxt = state;
        amp_nxt = amp;
        timer_nxt = timer;
        case (state)
            IDLE:    amp_nxt = '0;
            LAUNCH:  begin
                amp_nxt = '0;
                state_nxt = ATTACK;
            end
            ATTACK:  begin
                amp_nxt = (sum >= {1'b0, MAX_AMP}) ? MAX_AMP : sum[31:0];
                state_nxt = (sum >= {1'b0, MAX_AMP}) ? DECAY : ATTACK;
            end
            DECAY:   if (diff <= $signed({1'b0, sustain_level})) begin
                amp_nxt = sustain_level;
                timer_nxt = '0;
                state_nxt = SUSTAIN;
            end else amp_nxt = diff[31:0];
            // a zero sustain_time still yields one cycle, since tnext is at least 1
            SUSTAIN: begin
                timer_nxt = tnext[31:0];
                state_nxt = (tnext >= {1'b0, sustain_time}) ? RELEASE : SUSTAIN;
            end
            RELEASE: begin
                amp_nxt = (amp < release_step) ? '0 : amp - release_step;
                state_nxt = (amp < release_step) ? IDLE : RELEASE;
            end
            default: state_nxt = IDLE;
        endcase
        if (start) state_nxt = LAUNCH;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            amp <= '0;
            timer <= '0;
            attack_step <= '0;
            decay_step <= '0;
            sustain_level <= '0;
            sustain_time <= '0;
            release_step <= '0;
            bypass <= 1'b0;
            env_out <= '0;
        end else begin
            state <= state_nxt;
            amp <= amp_nxt;
            timer <= timer_nxt;
            bypass <= bypass_nxt;
            env_out <= bypass_nxt ? 16'h4000 : amp_nxt[31:16];
            if (wr) begin
                case (bus.addr[2:0])
                    3'd1: attack_step <= bus.write_data;
                    3'd2: decay_step <= bus.write_data;
                    3'd3: sustain_level <= bus.write_data;
                    3'd4: sustain_time <= bus.write_data;
                    3'd5: release_step <= bus.write_data;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mmio_adsr.sv
// tb_mmio_adsr: directed table, corner sequences and randomized envelopes against a stage-list model.
module tb_mmio_adsr;
    localparam longint MAX = 64'h4000_0000;
    logic clk = 1'b0;
    logic reset_n;
    logic [15:0] env_out;
    int checks = 0;
    int failures = 0;
    logic [16:0] exp_q[$];
    mmio_adsr_if bus();
    mmio_adsr dut (.clk(clk), .reset_n(reset_n), .bus(bus), .env_out(env_out));
    always #5 clk = ~clk;
    typedef struct packed {
        logic        do_wr;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [15:0] env;
        logic        idle;
    } row_t;
    row_t tbl[25];
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask
    task automatic chk_out(input string name, input logic [15:0] e, input logic i);
        check({name, " env"}, 32'(env_out), 32'(e));
        check({name, " status"}, bus.read_data, {15'b0, i, e});
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        bus.cs = 1'b1;
        bus.write = 1'b1;
        bus.addr = a;
        bus.write_data = d;
        tick();
        bus.cs = 1'b0;
        bus.write = 1'b0;
    endtask
    task automatic wait_idle(input string name);
        int n = 0;
        while (!bus.read_data[16] && n < 400) begin
            tick();
            n++;
        end
        check({name, " idle reached"}, 32'(bus.read_data[16]), 32'd1);
    endtask
    // Expected {idle, env} after each edge, starting with the start-write edge, from idle.
    function automatic void build(input longint at, input longint dt, input longint sl,
                                  input longint st, input longint rt);
        longint a = 0;
        exp_q.delete();
        exp_q.push_back(17'h0);
        exp_q.push_back(17'h0);
        while (1) begin
            a = a + at;
            if (a >= MAX) begin
                a = MAX;
                exp_q.push_back({1'b0, 16'(a >> 16)});
                break;
            end
            exp_q.push_back({1'b0, 16'(a >> 16)});
        end
        while (1) begin
            if (a - dt <= sl) begin
                a = sl;
                exp_q.push_back({1'b0, 16'(a >> 16)});
                break;
            end
            a = a - dt;
            exp_q.push_back({1'b0, 16'(a >> 16)});
        end
        repeat ((st == 0) ? 1 : int'(st)) exp_q.push_back({1'b0, 16'(a >> 16)});
        while (1) begin
            if (a < rt) begin
                exp_q.push_back({1'b1, 16'h0});
                break;
            end
            a = a - rt;
            exp_q.push_back({1'b0, 16'(a >> 16)});
        end
    endfunction
    task automatic run_env(input string name, input logic [31:0] at, input logic [31:0] dt,
                           input logic [31:0] sl, input logic [31:0] st, input logic [31:0] rt);
        wr({2'($urandom_range(0, 3)), 3'd1}, at);
        wr({2'($urandom_range(0, 3)), 3'd2}, dt);
        wr({2'($urandom_range(0, 3)), 3'd3}, sl);
        wr({2'($urandom_range(0, 3)), 3'd4}, st);
        wr({2'($urandom_range(0, 3)), 3'd5}, rt);
        build(longint'(at), longint'(dt), longint'(sl), longint'(st), longint'(rt));
        wr({2'($urandom_range(0, 3)), 3'd0}, $urandom);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i > 0) tick();
            chk_out($sformatf("%s[%0d]", name, i), exp_q[i][15:0], exp_q[i][16]);
        end
    endtask
    initial begin
        bus.cs = 1'b0;
        bus.write = 1'b0;
        bus.read = 1'b0;
        bus.addr = '0;
        bus.write_data = '0;
        reset_n = 1'b0;
        #22 reset_n = 1'b1;
        bus.read = 1'b1;
        tick();
        check("reset read_data", bus.read_data, 32'h0001_0000);
        check("reset env_out", 32'(env_out), 32'h0);
        tbl = '{
            '{1'b1, 5'd1, 32'h1000_0000, 16'h0000, 1'b1},
            '{1'b1, 5'd2, 32'h0800_0000, 16'h0000, 1'b1},
            '{1'b1, 5'd3, 32'h2000_0000, 16'h0000, 1'b1},
            '{1'b1, 5'd4, 32'h0000_0003, 16'h0000, 1'b1},
            '{1'b1, 5'd5, 32'h0C00_0000, 16'h0000, 1'b1},
            '{1'b1, 5'd6, 32'h0000_0001, 16'h4000, 1'b1},
            '{1'b1, 5'd7, 32'hFFFF_FFFF, 16'h4000, 1'b1},
            '{1'b1, 5'd6, 32'h0000_0000, 16'h0000, 1'b1},
            '{1'b1, 5'd0, 32'hDEAD_BEEF, 16'h0000, 1'b0},
            '{1'b0, 5'd0, 32'h0,         16'h0000, 1'b0},
            '{1'b0, 5'd0, 32'h0,         16'h1000, 1'b0},
            '{1'b0, 5'd0, 32'h0,         16'h2000, 1'b0},
            '{1'b0, 5'd0, 32'h0,         16'h3000, 1'b0},
            '{1'b0, 5'd0, 32'h0,         16'h4000, 1'b0},
            '{1'b0, 5'd0, 32'h0,         16'h3800, 1'b0},
            '{1'b0, 5'd0, 32'h0,         16'h3000, 1'b0},
            '{1'b0, 5'd0, 32'h0,         16'h2800, 1'b0},
            '{1'b0, 5'd0, 32'h0,         16'h2000, 1'b0},
            '{1'b0, 5'd0, 32'h0,         16'h2000, 1'b0},
            '{1'b0, 5'd0, 32'h0,         16'h2000, 1'b0},
            '{1'b0, 5'd0, 32'h0,         16'h2000, 1'b0},
            '{1'b0, 5'd0, 32'h0,         16'h1400, 1'b0},
            '{1'b0, 5'd0, 32'h0,         16'h0800, 1'b0},
            '{1'b0, 5'd0, 32'h0,         16'h0000, 1'b1},
            '{1'b0, 5'd0, 32'h0,         16'h0000, 1'b1}
        };
        for (int i = 0; i < 25; i++) begin
            if (tbl[i].do_wr) wr(tbl[i].addr, tbl[i].data);
            else tick();
            chk_out($sformatf("table[%0d]", i), tbl[i].env, tbl[i].idle);
        end
        // attack overshoot clamps at full scale
        wr(5'd1, 32'h3000_0000);
        wr(5'd0, 32'h0);
        tick();
        tick();
        chk_out("clamp first", 16'h3000, 1'b0);
        tick();
        chk_out("clamp full", 16'h4000, 1'b0);
        wait_idle("clamp");
        // retrigger while sustaining
        wr(5'd1, 32'h1000_0000);
        wr(5'd0, 32'h0);
        repeat (9) tick();
        chk_out("pre-retrigger sustain", 16'h2000, 1'b0);
        wr(5'd0, 32'h0);
        check("retrigger busy", 32'(bus.read_data[16]), 32'd0);
        tick();
        chk_out("retrigger launch", 16'h0000, 1'b0);
        tick();
        chk_out("retrigger attack", 16'h1000, 1'b0);
        wait_idle("retrigger");
        run_env("sustain0", 32'h1000_0000, 32'h0800_0000, 32'h2000_0000, 32'h0, 32'h0C00_0000);
        // bypass mid-attack: output pinned while the envelope keeps running
        wr(5'd1, 32'h0400_0000);
        wr(5'd0, 32'h0);
        repeat (3) tick();
        chk_out("pre-bypass", 16'h0800, 1'b0);
        wr(5'd6, 32'h1);
        chk_out("bypass on", 16'h4000, 1'b0);
        wait_idle("bypass run");
        check("bypass idle env", 32'(env_out), 32'h4000);
        wr(5'd6, 32'h0);
        chk_out("bypass off", 16'h0000, 1'b1);
        // asynchronous abort during decay
        wr(5'd1, 32'h1000_0000);
        wr(5'd2, 32'h0100_0000);
        wr(5'd0, 32'h0);
        repeat (7) tick();
        chk_out("pre-abort decay", 16'h3E00, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        check("abort env", 32'(env_out), 32'h0);
        check("abort status", bus.read_data, 32'h0001_0000);
        #3 reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_out($sformatf("post-abort[%0d]", i), 16'h0000, 1'b1);
        end
        for (int k = 0; k < 8; k++) begin
            run_env($sformatf("rand%0d", k),
                    $urandom_range(32'h4000_0000, 32'h0080_0000),
                    $urandom_range(32'h2000_0000, 32'h0080_0000),
                    $urandom_range(32'h5000_0000, 32'h0),
                    $urandom_range(6, 0),
                    $urandom_range(32'h2000_0000, 32'h0080_0000));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
